// File: rtl/pc_fetch_seq_pkg.sv
// Shared definitions for the program-counter / instruction-fetch sequencer.
package pc_fetch_seq_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned INST_W     = 32;
  localparam int unsigned INST_BYTES = 4;

  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
  } inst_pkt_t;

  function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_seq_redirect.sv
// Deferred-redirect holder: aligns branch targets, parks one while a fetch is in flight,
// and flags misaligned targets.
module pc_redirect_reg
  import pc_fetch_seq_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              br_taken_i,
  input  logic [ADDR_W-1:0] br_target_i,
  input  logic              capture_i,
  input  logic              clear_i,
  output logic              pend_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [ADDR_W-1:0] target_c_o,
  output logic              misalign_o
);

  logic              pend_q;
  logic [ADDR_W-1:0] addr_q;
  logic              misalign_q;

  assign target_c_o = align_word(br_target_i);

  // Latest capture overwrites an older parked target.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q     <= 1'b0;
      addr_q     <= '0;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= br_taken_i & (br_target_i[1:0] != 2'b00);
      if (clear_i) begin
        pend_q <= 1'b0;
      end else if (capture_i) begin
        pend_q <= 1'b1;
        addr_q <= target_c_o;
      end
    end
  end

  assign pend_o     = pend_q;
  assign addr_o     = addr_q;
  assign misalign_o = misalign_q;

endmodule

// File: rtl/pc_fetch_seq.sv
// Program counter and fetch sequencer: req/ack to instruction memory, valid/ready to decode,
// redirects applied only at handshake boundaries so wrong-path data is dropped.
module pc_fetch_seq
  import pc_fetch_seq_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_Br_taken,
  input  logic [ADDR_W-1:0] iv_Br_target,
  output logic              o_Imem_req,
  output logic [ADDR_W-1:0] ov_Imem_addr,
  input  logic              i_Imem_ack,
  input  logic [INST_W-1:0] iv_Imem_data,
  output logic              o_Inst_valid,
  output logic [INST_W-1:0] ov_Inst,
  output logic [ADDR_W-1:0] ov_Inst_pc,
  input  logic              i_Inst_ready,
  output logic              o_Flush,
  output logic              o_Misalign
);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] pc_q;
  inst_pkt_t         inst_q;
  logic              req_q;
  logic              valid_q;
  logic              flush_q;

  logic              redir_pend;
  logic [ADDR_W-1:0] redir_addr;
  logic [ADDR_W-1:0] target_al;
  logic              in_fetch_c;

  assign in_fetch_c = (state_q == S_FETCH);

  pc_redirect_reg u_redirect (
    .clk_i       (i_Clk),
    .rst_i       (i_Rst),
    .br_taken_i  (i_Br_taken),
    .br_target_i (iv_Br_target),
    .capture_i   (in_fetch_c & ~i_Imem_ack & i_Br_taken),
    .clear_i     (in_fetch_c & i_Imem_ack),
    .pend_o      (redir_pend),
    .addr_o      (redir_addr),
    .target_c_o  (target_al),
    .misalign_o  (o_Misalign)
  );

  // Sequencer; req/valid are registered alongside the state they decode.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      flush_q <= i_Br_taken;
      unique case (state_q)
        S_BOOT: begin
          state_q <= S_FETCH;
          req_q   <= 1'b1;
          if (i_Br_taken) pc_q <= target_al;
        end
        S_FETCH: begin
          if (i_Imem_ack) begin
            if (i_Br_taken) begin
              pc_q <= target_al;
            end else if (redir_pend) begin
              pc_q <= redir_addr;
            end else begin
              inst_q.inst <= iv_Imem_data;
              inst_q.pc   <= pc_q;
              pc_q        <= pc_q + ADDR_W'(INST_BYTES);
              state_q     <= S_HOLD;
              req_q       <= 1'b0;
              valid_q     <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          // A branch squashes the held instruction even if decode is ready.
          if (i_Br_taken) begin
            pc_q    <= target_al;
            state_q <= S_FETCH;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
          end else if (i_Inst_ready) begin
            state_q <= S_FETCH;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= S_BOOT;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_Imem_req   = req_q;
  assign ov_Imem_addr = pc_q;
  assign o_Inst_valid = valid_q;
  assign ov_Inst      = inst_q.inst;
  assign ov_Inst_pc   = inst_q.pc;
  assign o_Flush      = flush_q;

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Directed bench for pc_fetch_seq: vector table on a RESET_PC=0 instance, hand sequences
// on a RESET_PC=FFFF_FFFC instance for wrap, boot redirect and mid-request reset.
module tb_pc_fetch_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance A
  logic        rst_a, br_a, ack_a, rdy_a;
  logic [31:0] tgt_a, data_a;
  logic        req_a, vld_a, fl_a, mis_a;
  logic [31:0] addr_a, inst_a, ipc_a;

  // Instance B
  logic        rst_b, br_b, ack_b, rdy_b;
  logic [31:0] tgt_b, data_b;
  logic        req_b, vld_b, fl_b, mis_b;
  logic [31:0] addr_b, inst_b, ipc_b;

  pc_fetch_seq #(.RESET_PC(32'h0000_0000)) dut_a (
    .i_Clk(clk), .i_Rst(rst_a), .i_Br_taken(br_a), .iv_Br_target(tgt_a),
    .o_Imem_req(req_a), .ov_Imem_addr(addr_a), .i_Imem_ack(ack_a), .iv_Imem_data(data_a),
    .o_Inst_valid(vld_a), .ov_Inst(inst_a), .ov_Inst_pc(ipc_a), .i_Inst_ready(rdy_a),
    .o_Flush(fl_a), .o_Misalign(mis_a)
  );

  pc_fetch_seq #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
    .i_Clk(clk), .i_Rst(rst_b), .i_Br_taken(br_b), .iv_Br_target(tgt_b),
    .o_Imem_req(req_b), .ov_Imem_addr(addr_b), .i_Imem_ack(ack_b), .iv_Imem_data(data_b),
    .o_Inst_valid(vld_b), .ov_Inst(inst_b), .ov_Inst_pc(ipc_b), .i_Inst_ready(rdy_b),
    .o_Flush(fl_b), .o_Misalign(mis_b)
  );

  typedef struct {
    logic        br;
    logic [31:0] tgt;
    logic        ack;
    logic [31:0] data;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] inst;
    logic [31:0] ipc;
    logic        fl;
    logic        mis;
  } vec_t;

  localparam int NV = 29;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic br, input logic [31:0] tgt, input logic ack,
                              input logic [31:0] data, input logic rdy, input logic req,
                              input logic [31:0] addr, input logic vld, input logic [31:0] inst,
                              input logic [31:0] ipc, input logic fl, input logic mis);
    vec_t v;
    v.br = br; v.tgt = tgt; v.ack = ack; v.data = data; v.rdy = rdy;
    v.req = req; v.addr = addr; v.vld = vld; v.inst = inst; v.ipc = ipc;
    v.fl = fl; v.mis = mis;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic req, input logic [31:0] addr,
                       input logic vld, input logic fl, input logic mis);
    chk({tag, ".req"},  32'(req_a), 32'(req));
    chk({tag, ".addr"}, addr_a, addr);
    chk({tag, ".vld"},  32'(vld_a), 32'(vld));
    chk({tag, ".fl"},   32'(fl_a), 32'(fl));
    chk({tag, ".mis"},  32'(mis_a), 32'(mis));
  endtask

  task automatic chk_b(input string tag, input logic req, input logic [31:0] addr,
                       input logic vld, input logic fl);
    chk({tag, ".req"},  32'(req_b), 32'(req));
    chk({tag, ".addr"}, addr_b, addr);
    chk({tag, ".vld"},  32'(vld_b), 32'(vld));
    chk({tag, ".fl"},   32'(fl_b), 32'(fl));
  endtask

  initial begin
    // br, tgt, ack, data, rdy | req, addr, vld, inst, ipc, fl, mis
    vecs[0]  = mk(0, 0,     0, 0,            0, 1, 32'h000, 0, 0,            0,     0, 0);
    vecs[1]  = mk(0, 0,     1, 32'hA5A5A5A5, 1, 0, 32'h004, 1, 32'hA5A5A5A5, 32'h0, 0, 0);
    vecs[2]  = mk(0, 0,     0, 0,            1, 1, 32'h004, 0, 0,            0,     0, 0);
    vecs[3]  = mk(0, 0,     1, 32'hA5A5A5A1, 0, 0, 32'h008, 1, 32'hA5A5A5A1, 32'h4, 0, 0);
    vecs[4]  = mk(0, 0,     0, 0,            1, 1, 32'h008, 0, 0,            0,     0, 0);
    vecs[5]  = mk(0, 0,     1, 32'hA5A5A5AD, 0, 0, 32'h00C, 1, 32'hA5A5A5AD, 32'h8, 0, 0);
    vecs[6]  = mk(0, 0,     0, 0,            1, 1, 32'h00C, 0, 0,            0,     0, 0);
    vecs[7]  = mk(0, 0,     1, 32'hA5A5A5A9, 0, 0, 32'h010, 1, 32'hA5A5A5A9, 32'hC, 0, 0);
    vecs[8]  = mk(0, 0,     0, 0,            0, 0, 32'h010, 1, 32'hA5A5A5A9, 32'hC, 0, 0);
    vecs[9]  = mk(0, 0,     0, 0,            0, 0, 32'h010, 1, 32'hA5A5A5A9, 32'hC, 0, 0);
    vecs[10] = mk(0, 0,     1, 32'hDEADBEEF, 0, 0, 32'h010, 1, 32'hA5A5A5A9, 32'hC, 0, 0);
    vecs[11] = mk(0, 0,     0, 0,            0, 0, 32'h010, 1, 32'hA5A5A5A9, 32'hC, 0, 0);
    vecs[12] = mk(0, 0,     0, 0,            0, 0, 32'h010, 1, 32'hA5A5A5A9, 32'hC, 0, 0);
    vecs[13] = mk(0, 0,     0, 0,            1, 1, 32'h010, 0, 0,            0,     0, 0);
    vecs[14] = mk(1, 'h200, 0, 0,            0, 1, 32'h010, 0, 0,            0,     1, 0);
    vecs[15] = mk(0, 0,     0, 0,            0, 1, 32'h010, 0, 0,            0,     0, 0);
    vecs[16] = mk(1, 'h300, 0, 0,            0, 1, 32'h010, 0, 0,            0,     1, 0);
    vecs[17] = mk(0, 0,     1, 32'h11111111, 0, 1, 32'h300, 0, 0,            0,     0, 0);
    vecs[18] = mk(0, 0,     1, 32'hA5A5A6A5, 0, 0, 32'h304, 1, 32'hA5A5A6A5, 32'h300, 0, 0);
    vecs[19] = mk(1, 'h40,  0, 0,            1, 1, 32'h040, 0, 0,            0,     1, 0);
    vecs[20] = mk(1, 'h40,  1, 32'h22222222, 0, 1, 32'h040, 0, 0,            0,     1, 0);
    vecs[21] = mk(0, 0,     0, 0,            0, 1, 32'h040, 0, 0,            0,     0, 0);
    vecs[22] = mk(0, 0,     1, 32'hA5A5A5E5, 0, 0, 32'h044, 1, 32'hA5A5A5E5, 32'h40, 0, 0);
    vecs[23] = mk(1, 'h102, 0, 0,            0, 1, 32'h100, 0, 0,            0,     1, 1);
    vecs[24] = mk(0, 0,     0, 0,            0, 1, 32'h100, 0, 0,            0,     0, 0);
    vecs[25] = mk(1, 'h207, 0, 0,            0, 1, 32'h100, 0, 0,            0,     1, 1);
    vecs[26] = mk(0, 0,     1, 32'h33333333, 0, 1, 32'h204, 0, 0,            0,     0, 0);
    vecs[27] = mk(0, 0,     1, 32'hA5A5A7A1, 0, 0, 32'h208, 1, 32'hA5A5A7A1, 32'h204, 0, 0);
    vecs[28] = mk(0, 0,     0, 0,            1, 1, 32'h208, 0, 0,            0,     0, 0);

    rst_a = 1; br_a = 0; tgt_a = 0; ack_a = 0; data_a = 0; rdy_a = 0;
    rst_b = 1; br_b = 0; tgt_b = 0; ack_b = 0; data_b = 0; rdy_b = 0;
    tick();
    tick();
    chk_a("rstA", 0, 32'h0, 0, 0, 0);
    chk("rstA.inst", inst_a, 32'h0);
    chk("rstA.ipc",  ipc_a,  32'h0);
    chk_b("rstB", 0, 32'hFFFF_FFFC, 0, 0);

    rst_a = 0;
    for (int i = 0; i < NV; i++) begin
      br_a = vecs[i].br; tgt_a = vecs[i].tgt; ack_a = vecs[i].ack;
      data_a = vecs[i].data; rdy_a = vecs[i].rdy;
      tick();
      chk_a($sformatf("v%0d", i), vecs[i].req, vecs[i].addr, vecs[i].vld, vecs[i].fl, vecs[i].mis);
      if (vecs[i].vld) begin
        chk($sformatf("v%0d.inst", i), inst_a, vecs[i].inst);
        chk($sformatf("v%0d.ipc", i),  ipc_a,  vecs[i].ipc);
      end
    end
    br_a = 0; ack_a = 0; rdy_a = 0;

    // Wrap of pc+4 from the top of the address space
    rst_b = 0;
    tick();
    chk_b("b_boot", 1, 32'hFFFF_FFFC, 0, 0);
    ack_b = 1; data_b = 32'h1234_5678;
    tick();
    ack_b = 0;
    chk_b("b_hold", 0, 32'h0000_0000, 1, 0);
    chk("b_hold.inst", inst_b, 32'h1234_5678);
    chk("b_hold.ipc",  ipc_b,  32'hFFFF_FFFC);
    rdy_b = 1;
    tick();
    rdy_b = 0;
    chk_b("b_fetch0", 1, 32'h0000_0000, 0, 0);
    tick();
    chk_b("b_wait", 1, 32'h0000_0000, 0, 0);

    // Reset while the request to 0 is outstanding
    rst_b = 1;
    tick();
    chk_b("b_rst", 0, 32'hFFFF_FFFC, 0, 0);
    rst_b = 0;
    tick();
    chk_b("b_refetch", 1, 32'hFFFF_FFFC, 0, 0);

    // Branch taken during the boot cycle
    rst_b = 1;
    tick();
    rst_b = 0; br_b = 1; tgt_b = 32'h0000_0050;
    tick();
    br_b = 0;
    chk_b("b_bootbr", 1, 32'h0000_0050, 0, 1);
    tick();
    chk_b("b_bootbr2", 1, 32'h0000_0050, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
